// File: rtl/conv_mac_seq_pkg.sv
// conv_pkg: shared definitions for the conv_mac_seq dot-product sequencer.
//   state_t     - FSM encoding (IDLE=0, ACCUM=1, HOLD=2)
//   *_DEF       - default widths/lengths used by the interface and the top
//   acc_w()     - accumulator width that cannot overflow for a given config
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int BUF_W_DEF  = 2;
  localparam int KLEN_DEF   = 4;

  // 2**bw products of (2**dw-1)^2 each fit in 2*dw+bw bits.
  function automatic int acc_w(input int dw, input int bw);
    return 2 * dw + bw;
  endfunction

  localparam int ACC_W_DEF = acc_w(DATA_W_DEF, BUF_W_DEF);

endpackage

// File: rtl/conv_mac_seq_if.sv
// conv_mac_seq_if: request, operand-buffer and result-handshake bundle.
//   master - requester/buffer side: drives start, abort, bases, read data,
//            res_ready; observes read addresses, busy, result, res_valid.
//   slave  - the sequencer (conv_mac_seq).
interface conv_mac_seq_if
  import conv_pkg::*;
#(
  parameter int DataWidth   = DATA_W_DEF,
  parameter int BufferWidth = BUF_W_DEF,
  parameter int AccWidth    = 2 * DataWidth + BufferWidth
) ();

  logic                   start;
  logic                   abort;
  logic [BufferWidth-1:0] base1;
  logic [BufferWidth-1:0] base2;
  logic [BufferWidth-1:0] R_Addr1;
  logic [BufferWidth-1:0] R_Addr2;
  logic [DataWidth-1:0]   DataIn1;
  logic [DataWidth-1:0]   DataIn2;
  logic                   busy;
  logic [AccWidth-1:0]    result;
  logic                   res_valid;
  logic                   res_ready;

  modport master (
    output start, abort, base1, base2, DataIn1, DataIn2, res_ready,
    input  R_Addr1, R_Addr2, busy, result, res_valid
  );

  modport slave (
    input  start, abort, base1, base2, DataIn1, DataIn2, res_ready,
    output R_Addr1, R_Addr2, busy, result, res_valid
  );

endinterface

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sequential unsigned dot product of two KernelLen-long
// windows read from a two-port operand buffer with combinational reads.
//   clk     - rising-edge clock
//   aclr_n  - asynchronous active-low reset
//   bus     - conv_mac_seq_if.slave: start/abort/bases in, read addresses
//             out, read data in, busy, result + valid/ready handshake
// One product is accumulated per ACCUM cycle; the final sum is parked in
// HOLD until the consumer takes it (or abort/reset throws it away).
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int DataWidth   = DATA_W_DEF,
  parameter int BufferWidth = BUF_W_DEF,
  parameter int KernelLen   = KLEN_DEF,
  parameter int AccWidth    = 2 * DataWidth + BufferWidth
) (
  input logic           clk,
  input logic           aclr_n,
  conv_mac_seq_if.slave bus
);

  // One extra bit so KernelLen == 2**BufferWidth is representable.
  localparam int IdxW  = BufferWidth + 1;
  localparam int ProdW = 2 * DataWidth;

  state_t                 state;
  logic [IdxW-1:0]        idx;
  logic [BufferWidth-1:0] b1, b2;
  logic [AccWidth-1:0]    acc;
  logic [AccWidth-1:0]    result_q;
  logic                   res_valid_q;
  logic                   busy_q;

  logic [BufferWidth-1:0] addr1, addr2;
  logic [ProdW-1:0]       prod;
  logic [AccWidth-1:0]    acc_nxt;
  logic                   last;

  // Window addresses wrap silently modulo the buffer depth.
  assign addr1   = b1 + idx[BufferWidth-1:0];
  assign addr2   = b2 + idx[BufferWidth-1:0];
  assign prod    = {{DataWidth{1'b0}}, bus.DataIn1} * {{DataWidth{1'b0}}, bus.DataIn2};
  assign acc_nxt = acc + AccWidth'(prod);
  assign last    = (idx == IdxW'(KernelLen - 1));

  // Reads are combinational, so addresses cannot be registered without
  // costing a cycle; reset gating keeps them at 0 while aclr_n is low.
  // IDLE passes the live bases through so the buffer is pre-addressed.
  assign bus.R_Addr1 = !aclr_n ? '0 : (state == IDLE) ? bus.base1 : addr1;
  assign bus.R_Addr2 = !aclr_n ? '0 : (state == IDLE) ? bus.base2 : addr2;

  assign bus.result    = result_q;
  assign bus.res_valid = res_valid_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state       <= IDLE;
      idx         <= '0;
      b1          <= '0;
      b2          <= '0;
      acc         <= '0;
      result_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.abort) begin
      // Cancel wins over start and res_ready; result keeps its old value.
      state       <= IDLE;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            b1     <= bus.base1;
            b2     <= bus.base2;
            acc    <= '0;
            idx    <= '0;
            busy_q <= 1'b1;
            state  <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc_nxt;
          idx <= idx + IdxW'(1);
          if (last) begin
            result_q    <= acc_nxt;
            res_valid_q <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          // Exit costs one IDLE cycle, so a held start restarts a cycle later.
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench for conv_mac_seq (DataWidth=8, BufferWidth=2, KernelLen=4).
module tb_conv_mac_seq;

  localparam int DW = 8;
  localparam int BW = 2;
  localparam int K  = 4;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic aclr_n;

  conv_mac_seq_if #(.DataWidth(DW), .BufferWidth(BW), .AccWidth(AW)) ifc ();

  conv_mac_seq #(.DataWidth(DW), .BufferWidth(BW), .KernelLen(K), .AccWidth(AW)) dut (
    .clk    (clk),
    .aclr_n (aclr_n),
    .bus    (ifc)
  );

  always #5 clk = ~clk;

  // Two-port operand buffer with combinational reads.
  logic [DW-1:0] mem1 [4];
  logic [DW-1:0] mem2 [4];
  assign ifc.DataIn1 = mem1[ifc.R_Addr1];
  assign ifc.DataIn2 = mem2[ifc.R_Addr2];

  typedef struct {
    logic [BW-1:0]      b1;
    logic [BW-1:0]      b2;
    logic [3:0][DW-1:0] m1;
    logic [3:0][DW-1:0] m2;
    longint             r;
  } vec_t;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int b1, input int b2,
                              input int a0, input int a1, input int a2, input int a3,
                              input int c0, input int c1, input int c2, input int c3,
                              input longint r);
    vec_t v;
    v.b1 = b1[BW-1:0];
    v.b2 = b2[BW-1:0];
    v.m1[0] = a0[DW-1:0]; v.m1[1] = a1[DW-1:0]; v.m1[2] = a2[DW-1:0]; v.m1[3] = a3[DW-1:0];
    v.m2[0] = c0[DW-1:0]; v.m2[1] = c1[DW-1:0]; v.m2[2] = c2[DW-1:0]; v.m2[3] = c3[DW-1:0];
    v.r = r;
    return v;
  endfunction

  task automatic load(input vec_t v);
    for (int i = 0; i < 4; i++) begin
      mem1[i] = v.m1[i];
      mem2[i] = v.m2[i];
    end
  endtask

  // Start in cycle 0, check addresses through ACCUM (cycles 1..K), expect
  // the result in cycle K+1, stall `stall` cycles, then hand it off.
  task automatic run_vec(input string nm, input vec_t v, input int stall);
    logic [BW-1:0] e1, e2;
    load(v);
    ifc.base1 = v.b1;
    ifc.base2 = v.b2;
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    // Scramble the live bases: the DUT must use the latched copies.
    ifc.base1 = ~v.b1;
    ifc.base2 = ~v.b2;
    for (int c = 1; c <= K; c++) begin
      e1 = v.b1 + BW'(c - 1);
      e2 = v.b2 + BW'(c - 1);
      chk({nm, " addr1"}, ifc.R_Addr1, e1);
      chk({nm, " addr2"}, ifc.R_Addr2, e2);
      chk({nm, " busy"}, ifc.busy, 1);
      chk({nm, " early_valid"}, ifc.res_valid, 0);
      step();
    end
    chk({nm, " valid"}, ifc.res_valid, 1);
    chk({nm, " result"}, ifc.result, v.r);
    for (int s = 0; s < stall; s++) begin
      step();
      chk({nm, " stall_valid"}, ifc.res_valid, 1);
      chk({nm, " stall_result"}, ifc.result, v.r);
    end
    ifc.res_ready = 1'b1;
    step();
    ifc.res_ready = 1'b0;
    chk({nm, " post_valid"}, ifc.res_valid, 0);
    chk({nm, " post_busy"}, ifc.busy, 0);
  endtask

  vec_t vt [5];

  initial begin
    longint prior;

    vt[0] = mk(0, 0, 1, 2, 3, 4,  1, 2, 3, 4,  30);
    vt[1] = mk(2, 3, 1, 2, 3, 4,  1, 2, 3, 4,  24);
    vt[2] = mk(0, 0, 255, 255, 255, 255,  255, 255, 255, 255,  260100);
    vt[3] = mk(1, 0, 5, 0, 7, 9,  2, 3, 4, 6,  87);
    vt[4] = mk(3, 3, 1, 2, 3, 4,  10, 20, 30, 40,  300);

    aclr_n        = 1'b0;
    ifc.start     = 1'b0;
    ifc.abort     = 1'b0;
    ifc.res_ready = 1'b0;
    ifc.base1     = 2'd1;
    ifc.base2     = 2'd3;
    for (int i = 0; i < 4; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    #3;
    chk("rst addr1", ifc.R_Addr1, 0);
    chk("rst addr2", ifc.R_Addr2, 0);
    chk("rst valid", ifc.res_valid, 0);
    chk("rst busy", ifc.busy, 0);
    chk("rst result", ifc.result, 0);
    #9 aclr_n = 1'b1;
    step();
    chk("idle pass addr1", ifc.R_Addr1, 1);
    chk("idle pass addr2", ifc.R_Addr2, 3);

    for (int i = 0; i < 5; i++)
      run_vec($sformatf("vec%0d", i), vt[i], (i == 2) ? 10 : 0);

    // Abort in the second ACCUM cycle.
    prior = 300;
    load(vt[2]);
    ifc.base1 = 0;
    ifc.base2 = 0;
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    step();
    ifc.abort = 1'b1;
    step();
    ifc.abort = 1'b0;
    chk("abort busy", ifc.busy, 0);
    chk("abort valid", ifc.res_valid, 0);
    chk("abort result", ifc.result, prior);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("abort no_valid", ifc.res_valid, 0);
      chk("abort still_idle", ifc.busy, 0);
    end

    // Abort beats a simultaneous start in IDLE.
    ifc.start = 1'b1;
    ifc.abort = 1'b1;
    step();
    ifc.start = 1'b0;
    ifc.abort = 1'b0;
    chk("abort_vs_start busy", ifc.busy, 0);

    // Asynchronous reset while holding a result.
    load(vt[3]);
    ifc.base1 = vt[3].b1;
    ifc.base2 = vt[3].b2;
    ifc.start = 1'b1;
    step();
    ifc.start = 1'b0;
    for (int c = 0; c < K; c++) step();
    chk("hold valid", ifc.res_valid, 1);
    chk("hold result", ifc.result, 87);
    #2 aclr_n = 1'b0;
    #1;
    chk("async valid", ifc.res_valid, 0);
    chk("async result", ifc.result, 0);
    chk("async busy", ifc.busy, 0);
    #1 aclr_n = 1'b1;
    step();
    chk("after_rst valid", ifc.res_valid, 0);
    run_vec("fresh", vt[1], 0);

    // start and res_ready held high: HOLD at cycles 5 and 11, IDLE at 6.
    load(vt[0]);
    ifc.base1     = 0;
    ifc.base2     = 0;
    ifc.res_ready = 1'b1;
    ifc.start     = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      chk($sformatf("b2b valid c%0d", c), ifc.res_valid, (c == 5 || c == 11) ? 1 : 0);
      chk($sformatf("b2b busy c%0d", c), ifc.busy, (c == 6) ? 0 : 1);
      if (c == 5 || c == 11)
        chk($sformatf("b2b result c%0d", c), ifc.result, 30);
    end
    ifc.start = 1'b0;
    step();
    ifc.res_ready = 1'b0;
    chk("b2b end busy", ifc.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
